// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-high segment patterns ({a,b,c,d,e,f,g})
// and the {anode, cathode} mode encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h7E;
    localparam logic [6:0] SEG_1    = 7'h30;
    localparam logic [6:0] SEG_2    = 7'h6D;
    localparam logic [6:0] SEG_3    = 7'h79;
    localparam logic [6:0] SEG_4    = 7'h33;
    localparam logic [6:0] SEG_5    = 7'h5B;
    localparam logic [6:0] SEG_6    = 7'h5F;
    localparam logic [6:0] SEG_7    = 7'h70;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h7B;
    localparam logic [6:0] SEG_DASH = 7'h01;

    localparam logic [6:0] SEG_OFF_RST = 7'h00;

    // Mode is {anode, cathode}; the other two codes are illegal.
    typedef enum logic [1:0] {
        CC = 2'b01,
        CA = 2'b10
    } mode_e;

endpackage

// File: rtl/bcd_to_sev_seg_if.sv
// Digit/mode inputs and segment output of the BCD-to-7-segment decoder.
interface bcd_to_sev_seg_if;

    logic [3:0] a;
    logic       anode;
    logic       cathode;
    logic [6:0] out;

    modport master (
        output a,
        output anode,
        output cathode,
        input  out
    );

    modport slave (
        input  a,
        input  anode,
        input  cathode,
        output out
    );

endinterface

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD digit to active-high segment pattern; non-BCD codes show a dash.
module bcd_seg_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] a,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (a)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_to_sev_seg.sv
// Registered BCD-to-7-segment decoder with run-time common-cathode/common-anode
// polarity; illegal mode codes drive all segments low.
module bcd_to_sev_seg
    import seg7_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bcd_to_sev_seg_if.slave bus
);

    logic [6:0] pattern;
    logic [6:0] out_d;
    logic [6:0] out_q;

    bcd_seg_decoder u_dec (
        .a   (bus.a),
        .seg (pattern)
    );

    always_comb begin
        out_d = SEG_OFF_RST;
        case ({bus.anode, bus.cathode})
            CC:      out_d = pattern;
            CA:      out_d = ~pattern;
            default: out_d = SEG_OFF_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= SEG_OFF_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_bcd_to_sev_seg.sv
// Directed and random checks of bcd_to_sev_seg against a bench-side pattern table.
module tb_bcd_to_sev_seg;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bcd_to_sev_seg_if bus ();

    bcd_to_sev_seg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_pat(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        return (d <= 4'd9) ? tbl[d] : 7'h01;
    endfunction

    function automatic logic [6:0] ref_out(input logic [3:0] d, input logic an,
                                           input logic ca, input logic r);
        if (r) return 7'h00;
        if (!an && ca) return ref_pat(d);
        if (an && !ca) return ~ref_pat(d);
        return 7'h00;
    endfunction

    // Apply inputs just after an edge, then step past the next rising edge.
    task automatic apply(input logic [3:0] d, input logic an, input logic ca, input logic r);
        bus.a       = d;
        bus.anode   = an;
        bus.cathode = ca;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] cc_exp [0:9];
        logic [6:0] held;
        logic [3:0] d;
        logic an;
        logic ca;
        logic r;
        n_cmp = 0;
        n_err = 0;
        cc_exp = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

        // Reset held for two edges with a live digit on the inputs.
        apply(4'd8, 1'b0, 1'b1, 1'b1);
        check_eq("reset_1", bus.out, 7'h00);
        apply(4'd8, 1'b0, 1'b1, 1'b1);
        check_eq("reset_2", bus.out, 7'h00);
        apply(4'd8, 1'b0, 1'b1, 1'b0);
        check_eq("reset_release", bus.out, 7'h7F);

        for (int i = 0; i < 10; i++) begin
            apply(4'(i), 1'b0, 1'b1, 1'b0);
            check_eq($sformatf("cc_%0d", i), bus.out, cc_exp[i]);
        end

        apply(4'd0, 1'b1, 1'b0, 1'b0);
        check_eq("ca_0", bus.out, 7'h01);
        apply(4'd1, 1'b1, 1'b0, 1'b0);
        check_eq("ca_1", bus.out, 7'h4F);
        apply(4'd8, 1'b1, 1'b0, 1'b0);
        check_eq("ca_8", bus.out, 7'h00);
        apply(4'd9, 1'b1, 1'b0, 1'b0);
        check_eq("ca_9", bus.out, 7'h04);

        for (int i = 10; i < 16; i++) begin
            apply(4'(i), 1'b0, 1'b1, 1'b0);
            check_eq($sformatf("cc_bad_%0d", i), bus.out, 7'h01);
            apply(4'(i), 1'b1, 1'b0, 1'b0);
            check_eq($sformatf("ca_bad_%0d", i), bus.out, 7'h7E);
        end

        apply(4'd5, 1'b0, 1'b0, 1'b0);
        check_eq("mode_00", bus.out, 7'h00);
        apply(4'd5, 1'b1, 1'b1, 1'b0);
        check_eq("mode_11", bus.out, 7'h00);
        apply(4'd5, 1'b0, 1'b1, 1'b0);
        check_eq("mode_to_cc", bus.out, 7'h5B);

        // Mid-cycle input changes must not reach the output before the next edge.
        held = bus.out;
        bus.a = 4'd2;
        bus.anode = 1'b1;
        bus.cathode = 1'b0;
        @(negedge clk);
        check_eq("no_comb_path", bus.out, held);
        @(posedge clk);
        #1;
        check_eq("mid_cycle_taken", bus.out, 7'h12);

        // Digit and mode changing together.
        apply(4'd7, 1'b0, 1'b1, 1'b0);
        check_eq("joint_change", bus.out, 7'h70);

        for (int i = 0; i < 200; i++) begin
            d  = 4'($urandom_range(0, 15));
            an = 1'($urandom_range(0, 1));
            ca = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 15) == 0);
            apply(d, an, ca, r);
            check_eq($sformatf("rand_%0d", i), bus.out, ref_out(d, an, ca, r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
